// File: rtl/host_dma_pkg.sv
// Shared types and constants for the host DMA responder.
// Optional feature macro used by the responder: HOST_DMA_RESP_BOUNDS_CHK_EN.
package host_dma_pkg;

  localparam int unsigned CL_BITS  = 512;
  localparam int unsigned CL_BYTES = 64;
  localparam int unsigned CL_SHIFT = $clog2(CL_BYTES);
  localparam int unsigned ADDR_W   = 64;

  typedef enum logic [2:0] {
    INIT    = 3'd0,
    IDLE    = 3'd1,
    RD_WAIT = 3'd2,
    RD_RESP = 3'd3,
    WR_WAIT = 3'd4,
    WR_DONE = 3'd5
  } state_e;

  // True for every state that holds a transaction in flight.
  function automatic logic is_busy(input state_e s);
    return (s == RD_WAIT) || (s == RD_RESP) || (s == WR_WAIT) || (s == WR_DONE);
  endfunction

endpackage

// File: rtl/host_dma_responder_ram.sv
// Cache-line store: DEPTH x 512, single port, synchronous write, registered read.
// The read register holds its value until the next read and clears on rst;
// the line array itself is never cleared.
// Optional feature macro of the enclosing design: HOST_DMA_RESP_BOUNDS_CHK_EN (i_rzero).
module host_line_ram
  import host_dma_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IDX_W-1:0]   i_addr,
  input  logic               i_we,
  input  logic [CL_BITS-1:0] i_wdata,
  input  logic               i_re,
  input  logic               i_rzero,
  output logic [CL_BITS-1:0] o_rdata
);

  logic [CL_BITS-1:0] r_mem [DEPTH];
  logic [CL_BITS-1:0] r_rdata;

  // Line write; storage survives reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  // Registered read, optionally forced to zero for rejected addresses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= i_rzero ? '0 : r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/host_dma_responder.sv
// Host DMA responder: models a host memory window of DEPTH cache lines with
// fixed read/write response latencies and a one-transaction-at-a-time protocol.
// Optional feature macro: HOST_DMA_RESP_BOUNDS_CHK_EN enables the address range
// check (out-of-range reads return zero, writes are dropped, resp_err is set).
module host_dma_responder
  import host_dma_pkg::*;
#(
  parameter int unsigned        DEPTH       = 64,
  parameter logic [ADDR_W-1:0]  BASE_ADDR   = 64'h0000_1000,
  parameter int unsigned        RD_LATENCY  = 4,
  parameter int unsigned        WR_LATENCY  = 2,
  parameter int unsigned        INIT_CYCLES = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               host_re,
  input  logic               host_rgo,
  input  logic               host_we,
  input  logic               host_wgo,
  input  logic [ADDR_W-1:0]  corrected_address,
  input  logic [CL_BITS-1:0] host_data_bus_write_out,
  output logic               host_init,
  output logic [ADDR_W-1:0]  address_offset,
  output logic               host_rd_ready,
  output logic [CL_BITS-1:0] host_data_bus_read_in,
  output logic               host_wr_ready,
  output logic               busy,
  output logic               resp_err
);

  localparam int unsigned IDX_W     = $clog2(DEPTH);
  localparam int unsigned MAX_LAT   = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
  localparam int unsigned MAX_CNT   = (MAX_LAT > INIT_CYCLES) ? MAX_LAT : INIT_CYCLES;
  localparam int unsigned CNT_W     = $clog2(MAX_CNT + 1);
  // The accept cycle and the response cycle are not spent in the wait states.
  localparam int unsigned RD_LOAD   = (RD_LATENCY >= 2) ? RD_LATENCY - 2 : 0;
  localparam int unsigned WR_LOAD   = (WR_LATENCY >= 2) ? WR_LATENCY - 2 : 0;
  localparam int unsigned INIT_LOAD = INIT_CYCLES - 1;

  state_e             r_state;
  state_e             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   w_live_idx;
  logic [IDX_W-1:0]   w_ram_addr;
  logic               r_oob;
  logic               w_live_oob;
  logic               w_ram_rzero;
  logic               w_ram_re;
  logic               w_ram_we;
  logic [CL_BITS-1:0] r_wdata;
  logic [CL_BITS-1:0] w_rd_data;
  logic               w_rd_go;
  logic               w_wr_go;
  logic               w_accept_rd;
  logic               w_accept_wr;
  logic               w_set_err;
  logic               r_host_init;
  logic               r_rd_ready;
  logic               r_wr_ready;
  logic               r_busy;
  logic               r_resp_err;

  assign w_rd_go    = host_rgo & host_re;
  assign w_wr_go    = host_wgo & host_we;
  // Line index relative to the window base; byte-in-line bits are dropped.
  assign w_live_idx = IDX_W'((corrected_address - BASE_ADDR) >> CL_SHIFT);

`ifdef HOST_DMA_RESP_BOUNDS_CHK_EN
  localparam logic [ADDR_W-1:0] END_ADDR = BASE_ADDR + ADDR_W'(CL_BYTES) * ADDR_W'(DEPTH);
  assign w_live_oob = (corrected_address < BASE_ADDR) || (corrected_address >= END_ADDR);
`else
  assign w_live_oob = 1'b0;
`endif

  // Next-state, counter and accept decode.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept_rd = 1'b0;
    w_accept_wr = 1'b0;
    w_set_err   = 1'b0;
    unique case (r_state)
      INIT: begin
        if (r_cnt == '0) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      IDLE: begin
        if (w_rd_go) begin
          w_accept_rd = 1'b1;
          w_set_err   = w_wr_go | w_live_oob;
          w_cnt_nxt   = CNT_W'(RD_LOAD);
          w_state_nxt = (RD_LATENCY < 2) ? RD_RESP : RD_WAIT;
        end else if (w_wr_go) begin
          w_accept_wr = 1'b1;
          w_set_err   = w_live_oob;
          w_cnt_nxt   = CNT_W'(WR_LOAD);
          w_state_nxt = (WR_LATENCY < 2) ? WR_DONE : WR_WAIT;
        end
      end
      RD_WAIT: begin
        if (r_cnt == '0) begin
          w_state_nxt = RD_RESP;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      RD_RESP: w_state_nxt = IDLE;
      WR_WAIT: begin
        if (r_cnt == '0) begin
          w_state_nxt = WR_DONE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      WR_DONE: w_state_nxt = IDLE;
      default: w_state_nxt = INIT;
    endcase
  end

  // State register and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= INIT;
      r_cnt       <= CNT_W'(INIT_LOAD);
      r_host_init <= 1'b0;
      r_rd_ready  <= 1'b0;
      r_wr_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_resp_err  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_host_init <= r_host_init | (w_state_nxt == IDLE);
      r_rd_ready  <= (w_state_nxt == RD_RESP);
      r_wr_ready  <= (w_state_nxt == WR_DONE);
      r_busy      <= is_busy(w_state_nxt);
      if (w_set_err) begin
        r_resp_err <= 1'b1;
      end
    end
  end

  // Request capture on accept; no reset needed since it is only used when busy.
  always_ff @(posedge clk) begin
    if (w_accept_rd || w_accept_wr) begin
      r_idx <= w_live_idx;
      r_oob <= w_live_oob;
    end
    if (w_accept_wr) begin
      r_wdata <= host_data_bus_write_out;
    end
  end

  // The RAM read is launched on the edge entering RD_RESP so its output
  // register is the read-data port; with unit latency that edge is the accept.
  assign w_ram_addr  = (r_state == IDLE) ? w_live_idx : r_idx;
  assign w_ram_rzero = (r_state == IDLE) ? w_live_oob : r_oob;
  assign w_ram_re    = (w_state_nxt == RD_RESP);
  assign w_ram_we    = (r_state == WR_DONE) && !r_oob;

  host_line_ram #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .i_addr  (w_ram_addr),
    .i_we    (w_ram_we),
    .i_wdata (r_wdata),
    .i_re    (w_ram_re),
    .i_rzero (w_ram_rzero),
    .o_rdata (w_rd_data)
  );

  assign host_init             = r_host_init;
  assign address_offset        = BASE_ADDR;
  assign host_rd_ready         = r_rd_ready;
  assign host_data_bus_read_in = w_rd_data;
  assign host_wr_ready         = r_wr_ready;
  assign busy                  = r_busy;
  assign resp_err              = r_resp_err;

endmodule

// File: tb/tb_host_dma_responder.sv
// Self-checking bench for host_dma_responder (default parameters).
// Honours HOST_DMA_RESP_BOUNDS_CHK_EN when the design is built with it.
module tb_host_dma_responder;

  localparam int unsigned DEPTH    = 64;
  localparam logic [63:0] BASE     = 64'h1000;
  localparam int          RD_LAT   = 4;
  localparam int          WR_LAT   = 2;
  localparam int          INIT_CYC = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         host_re = 1'b0;
  logic         host_rgo = 1'b0;
  logic         host_we = 1'b0;
  logic         host_wgo = 1'b0;
  logic [63:0]  corrected_address = '0;
  logic [511:0] host_data_bus_write_out = '0;
  logic         host_init;
  logic [63:0]  address_offset;
  logic         host_rd_ready;
  logic [511:0] host_data_bus_read_in;
  logic         host_wr_ready;
  logic         busy;
  logic         resp_err;

  host_dma_responder dut (
    .clk                     (clk),
    .rst                     (rst),
    .host_re                 (host_re),
    .host_rgo                (host_rgo),
    .host_we                 (host_we),
    .host_wgo                (host_wgo),
    .corrected_address       (corrected_address),
    .host_data_bus_write_out (host_data_bus_write_out),
    .host_init               (host_init),
    .address_offset          (address_offset),
    .host_rd_ready           (host_rd_ready),
    .host_data_bus_read_in   (host_data_bus_read_in),
    .host_wr_ready           (host_wr_ready),
    .busy                    (busy),
    .resp_err                (resp_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;

  typedef struct {
    logic [511:0] data;
    int           at;
  } rd_exp_t;

  rd_exp_t      rd_q[$];
  int           wr_q[$];
  logic [511:0] model [DEPTH];

  localparam logic [511:0] PAT_A5 = {64{8'hA5}};

  function automatic int line_of(input logic [63:0] a);
    logic [63:0] t;
    t = (a - BASE) >> 6;
    return int'(t[5:0]);
  endfunction

  function automatic bit oob(input logic [63:0] a);
`ifdef HOST_DMA_RESP_BOUNDS_CHK_EN
    return (a < BASE) || (a >= BASE + 64'(64 * DEPTH));
`else
    return (a == 64'hFFFF_FFFF_FFFF_FFFF) && (a != a);
`endif
  endfunction

  function automatic logic [511:0] exp_line(input logic [63:0] a);
    return oob(a) ? 512'd0 : model[line_of(a)];
  endfunction

  // Scoreboard: every ready pulse must match the head of its queue, on time.
  always @(negedge clk) begin : monitor
    rd_exp_t e;
    int      w;
    if (mon_en) begin
      n_tests++;
      if (address_offset !== BASE) begin
        n_fail++;
        $display("FAIL address_offset cyc=%0d got=%h want=%h", cyc, address_offset, BASE);
      end
      if (host_rd_ready === 1'b1) begin
        n_tests++;
        if (rd_q.size() == 0) begin
          n_fail++;
          $display("FAIL rd_unexpected cyc=%0d got pulse want none", cyc);
        end else begin
          e = rd_q.pop_front();
          if (cyc !== e.at || host_data_bus_read_in !== e.data) begin
            n_fail++;
            $display("FAIL rd_resp cyc got=%0d want=%0d data got=%h want=%h",
                     cyc, e.at, host_data_bus_read_in, e.data);
          end
        end
      end else if (rd_q.size() > 0 && rd_q[0].at < cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL rd_missing got no pulse want cyc=%0d", rd_q[0].at);
        void'(rd_q.pop_front());
      end
      if (host_wr_ready === 1'b1) begin
        n_tests++;
        if (wr_q.size() == 0) begin
          n_fail++;
          $display("FAIL wr_unexpected cyc=%0d got pulse want none", cyc);
        end else begin
          w = wr_q.pop_front();
          if (cyc !== w) begin
            n_fail++;
            $display("FAIL wr_resp cyc got=%0d want=%0d", cyc, w);
          end
        end
      end else if (wr_q.size() > 0 && wr_q[0] < cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL wr_missing got no pulse want cyc=%0d", wr_q[0]);
        void'(wr_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle read strobe; optionally records the expected response.
  task automatic drive_read(input logic [63:0] a, input logic [511:0] d, input bit exp_resp);
    corrected_address = a;
    host_rgo = 1'b1;
    host_re  = 1'b1;
    if (exp_resp) rd_q.push_back('{data: d, at: cyc + RD_LAT});
    tick();
    host_rgo = 1'b0;
    host_re  = 1'b0;
  endtask

  // One-cycle write strobe; records the pulse and the model update as told.
  task automatic drive_write(input logic [63:0] a, input logic [511:0] d,
                             input bit exp_resp, input bit commit);
    corrected_address       = a;
    host_data_bus_write_out = d;
    host_wgo = 1'b1;
    host_we  = 1'b1;
    if (exp_resp) wr_q.push_back(cyc + WR_LAT);
    if (commit) model[line_of(a)] = d;
    tick();
    host_wgo = 1'b0;
    host_we  = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while ((rd_q.size() != 0 || wr_q.size() != 0 || busy) && k < 40) begin
      tick();
      k++;
    end
    n_tests++;
    if (k >= 40) begin
      n_fail++;
      $display("FAIL %s_timeout got busy=%0b rdq=%0d wrq=%0d want drained",
               name, busy, rd_q.size(), wr_q.size());
      rd_q.delete();
      wr_q.delete();
    end
  endtask

  function automatic logic [511:0] rand_line();
    logic [511:0] d;
    for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic test_reset();
    int n = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mon_en = 1'b1;
    n_tests++;
    if ({host_init, host_rd_ready, host_wr_ready, busy, resp_err} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags got=%b want=00000",
               {host_init, host_rd_ready, host_wr_ready, busy, resp_err});
    end
    n_tests++;
    if (host_data_bus_read_in !== 512'd0) begin
      n_fail++;
      $display("FAIL reset_rdata got=%h want=0", host_data_bus_read_in);
    end
    while (host_init !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    n_tests++;
    if (n !== INIT_CYC) begin
      n_fail++;
      $display("FAIL init_delay got=%0d want=%0d", n, INIT_CYC);
    end
    tick();
    tick();
    n_tests++;
    if (host_init !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL init_hold got init=%0b busy=%0b want init=1 busy=0", host_init, busy);
    end
  endtask

  task automatic test_write_read();
    drive_write(64'h1040, PAT_A5, 1'b1, 1'b1);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_busy got=%0b want=1", busy);
    end
    wait_drain("write_a5");
    drive_read(64'h1040, PAT_A5, 1'b1);
    wait_drain("read_a5");
    tick();
    tick();
    n_tests++;
    if (host_data_bus_read_in !== PAT_A5) begin
      n_fail++;
      $display("FAIL rdata_hold got=%h want=%h", host_data_bus_read_in, PAT_A5);
    end
    drive_read(64'h107F, PAT_A5, 1'b1);
    wait_drain("read_low_bits");
  endtask

  task automatic test_busy_ignore();
    logic [511:0] d = rand_line();
    drive_write(64'h1080, d, 1'b1, 1'b1);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_wait_busy got=%0b want=1", busy);
    end
    drive_read(64'h1000, 512'd0, 1'b0);
    wait_drain("busy_ignore");
    repeat (RD_LAT + 2) tick();
    corrected_address = 64'h1080;
    host_rgo = 1'b1;
    host_re  = 1'b0;
    tick();
    host_rgo = 1'b0;
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL unqualified_rgo got busy=%0b want=0", busy);
    end
    drive_read(64'h1080, d, 1'b1);
    wait_drain("busy_readback");
  endtask

  task automatic test_wrap();
    logic [511:0] c = rand_line();
    logic [511:0] d = rand_line();
    bit           e = oob(64'h2000);
    drive_write(64'h1000, c, 1'b1, 1'b1);
    wait_drain("wrap_setup");
    drive_write(64'h2000, d, 1'b1, !e);
    wait_drain("wrap_write");
    n_tests++;
    if (resp_err !== e) begin
      n_fail++;
      $display("FAIL wrap_err got=%0b want=%0b", resp_err, e);
    end
    drive_read(64'h1000, model[0], 1'b1);
    wait_drain("wrap_line0");
    drive_read(64'h2000, exp_line(64'h2000), 1'b1);
    wait_drain("wrap_read");
  endtask

  task automatic test_dual_strobe();
    corrected_address       = 64'h1040;
    host_data_bus_write_out = rand_line();
    host_rgo = 1'b1;
    host_re  = 1'b1;
    host_wgo = 1'b1;
    host_we  = 1'b1;
    rd_q.push_back('{data: PAT_A5, at: cyc + RD_LAT});
    tick();
    host_rgo = 1'b0;
    host_re  = 1'b0;
    host_wgo = 1'b0;
    host_we  = 1'b0;
    wait_drain("dual");
    n_tests++;
    if (resp_err !== 1'b1) begin
      n_fail++;
      $display("FAIL dual_err got=%0b want=1", resp_err);
    end
    drive_read(64'h1040, PAT_A5, 1'b1);
    wait_drain("dual_readback");
  endtask

  task automatic test_rst_mid_write();
    int n = 0;
    drive_write(64'h1040, rand_line(), 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if ({busy, resp_err, host_wr_ready, host_init} !== 4'b0) begin
      n_fail++;
      $display("FAIL rst_mid_flags got=%b want=0000", {busy, resp_err, host_wr_ready, host_init});
    end
    n_tests++;
    if (host_data_bus_read_in !== 512'd0) begin
      n_fail++;
      $display("FAIL rst_mid_rdata got=%h want=0", host_data_bus_read_in);
    end
    while (host_init !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    n_tests++;
    if (n !== INIT_CYC) begin
      n_fail++;
      $display("FAIL rst_mid_init got=%0d want=%0d", n, INIT_CYC);
    end
    drive_read(64'h1040, PAT_A5, 1'b1);
    wait_drain("rst_mid_readback");
  endtask

  task automatic test_back_to_back();
    logic [63:0] a [8];
    for (int i = 0; i < 8; i++) begin
      a[i] = BASE + 64'((i * 5 + 7) % DEPTH) * 64 + 64'($urandom_range(0, 63));
      drive_write(a[i], rand_line(), 1'b1, 1'b1);
      wait_drain("b2b_write");
    end
    for (int i = 7; i >= 0; i--) begin
      drive_read(a[i], exp_line(a[i]), 1'b1);
      wait_drain("b2b_read");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_busy_ignore();
    test_wrap();
    test_dual_strobe();
    test_rst_mid_write();
    test_back_to_back();
    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/host_dma_responder.md
HOST_DMA_RESPONDER -- requirements
Module: host_dma_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning the number of 512-bit cache lines held (power of two, at least 2).
REQ-002 SHALL have parameter BASE_ADDR, default 64'h0000_1000, meaning the byte address of line 0, driven on address_offset.
REQ-003 SHALL have parameter RD_LATENCY, default 4, meaning cycles from host_rgo to host_rd_ready (at least 1).
REQ-004 SHALL have parameter WR_LATENCY, default 2, meaning cycles from host_wgo to host_wr_ready (at least 1).
REQ-005 SHALL have parameter INIT_CYCLES, default 8, meaning cycles after reset before host_init asserts (at least 1).
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have port host_re, input, 1 bit: read request qualifier.
REQ-009 SHALL have port host_rgo, input, 1 bit: one-cycle read start strobe.
REQ-010 SHALL have port host_we, input, 1 bit: write request qualifier.
REQ-011 SHALL have port host_wgo, input, 1 bit: one-cycle write start strobe.
REQ-012 SHALL have port corrected_address, input, 64 bits: request byte address.
REQ-013 SHALL have port host_data_bus_write_out, input, 512 bits: write line data.
REQ-014 SHALL have port host_init, output, 1 bit: responder initialised; address_offset is valid.
REQ-015 SHALL have port address_offset, output, 64 bits: base byte address.
REQ-016 SHALL have port host_rd_ready, output, 1 bit: one-cycle read-data-valid pulse.
REQ-017 SHALL have port host_data_bus_read_in, output, 512 bits: read line data.
REQ-018 SHALL have port host_wr_ready, output, 1 bit: one-cycle write-complete pulse.
REQ-019 SHALL have port busy, output, 1 bit: a transaction is in flight.
REQ-020 SHALL have port resp_err, output, 1 bit: sticky protocol/address error flag.

Function
REQ-021 SHALL implement the states INIT, IDLE, RD_WAIT, RD_RESP, WR_WAIT and WR_DONE.
REQ-022 SHALL count INIT_CYCLES in INIT, then go to IDLE with host_init high; host_init SHALL stay high until rst.
REQ-023 SHALL drive address_offset as BASE_ADDR at all times.
REQ-024 SHALL, in IDLE, accept a read when host_rgo and host_re are both high, capturing corrected_address, and go to RD_WAIT.
REQ-025 SHALL, in IDLE, accept a write when host_wgo and host_we are both high, capturing the address and host_data_bus_write_out in the same cycle, and go to WR_WAIT.
REQ-026 SHALL compute the line index as (addr - BASE_ADDR) >> 6, keeping the low log2(DEPTH) bits; addr[5:0] is ignored.
REQ-027 SHALL, for a read accepted at cycle T, pulse host_rd_ready high in cycle T+RD_LATENCY (RD_RESP) and present the line on host_data_bus_read_in in that same cycle.
REQ-028 SHALL hold host_data_bus_read_in until the next read response; its value is zero after reset.
REQ-029 SHALL, for a write accepted at cycle T, update the line in cycle T+WR_LATENCY (WR_DONE) and pulse host_wr_ready in that same cycle.
REQ-030 SHALL return to IDLE after RD_RESP or WR_DONE; the earliest next accept is the following cycle.
REQ-031 SHALL ignore strobes received in INIT or while busy, with no queueing.
REQ-032 SHALL, when host_rgo and host_wgo are both valid in the same cycle, serve the read only, drop the write, and set resp_err.
REQ-033 SHALL ignore a strobe whose qualifier (host_re or host_we) is low.
REQ-034 SHALL drive busy high in RD_WAIT, RD_RESP, WR_WAIT and WR_DONE.

Reset
REQ-035 SHALL, on rst, enter INIT with host_init=0, host_rd_ready=0, host_wr_ready=0, busy=0, resp_err=0 and host_data_bus_read_in=0.
REQ-036 SHALL, on rst mid-transaction, abandon the transaction: no ready pulse is issued and a pending write is not committed.
REQ-037 SHALL not clear line storage on rst.

Configuration
REQ-038 SHALL, with HOST_DMA_RESP_BOUNDS_CHK_EN defined, treat an address below BASE_ADDR or at/above BASE_ADDR+64*DEPTH as out of range: set resp_err, return zero data on reads, and discard writes (the ready pulse timing is unchanged).
REQ-039 SHALL, with HOST_DMA_RESP_BOUNDS_CHK_EN undefined, wrap the index modulo DEPTH and omit the range check; resp_err is then set only by REQ-032.

Structure
REQ-040 SHALL place the state enum and the CL_BITS=512 and CL_BYTES=64 constants in package host_dma_pkg.
REQ-041 SHALL use one sub-module, host_line_ram (DEPTH x 512, single-port, synchronous write, registered read), sized so that RD_LATENCY includes its read cycle.

Verification
REQ-042 SHALL check: rst for 1 cycle -> host_init rises exactly 8 cycles later; address_offset = 64'h1000 throughout.
REQ-043 SHALL check: write 512'hA5..A5 to 64'h1040 at T -> host_wr_ready pulses for exactly 1 cycle at T+2; a subsequent read of 64'h1040 at T' -> host_rd_ready at T'+4 with data A5..A5.
REQ-044 SHALL check: a read at 64'h1000 while a write is in WR_WAIT -> the read is ignored, with no host_rd_ready pulse.
REQ-045 SHALL check: host_rgo and host_wgo high in the same cycle -> only host_rd_ready pulses, line unchanged, resp_err = 1.
REQ-046 SHALL check: a write to 64'h2000 with the macro defined -> resp_err = 1 and line 0 unchanged; without the macro -> line 0 is overwritten (wrap).
REQ-047 SHALL check: rst asserted one cycle after host_wgo -> no host_wr_ready pulse and the target line keeps its old value.
